// File: rtl/snes_joy_pkg.sv
// Shared types for the SNES controller-port master: FSM state, pad word width.
package snes_joy_pkg;

  localparam int JOY_BITS = 16;

  typedef logic [JOY_BITS-1:0] joy_word_t;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    BIT_LO,
    BIT_HI
  } joy_state_t;

  // Pads report the first-shifted button in the MSB once all bits are in.
  function automatic joy_word_t shift_in(input joy_word_t w, input logic b);
    return {w[JOY_BITS-2:0], b};
  endfunction

endpackage

// File: rtl/joy_autoread_if.sv
// CPU register strobes plus the two controller-port lines, seen from either side.
interface joy_autoread_if;
  import snes_joy_pkg::*;

  logic       AUTO_EN;
  logic       VBLANK_START;
  logic       WRIO7;
  logic       LATCH_WR;
  logic       LATCH_D;
  logic       RD4016;
  logic       RD4017;
  logic [1:0] P1_DO;
  logic [1:0] P2_DO;

  logic       PORT_LATCH;
  logic       P1_CLK;
  logic       P2_CLK;
  logic       PORT_P6;
  logic [1:0] RD_DATA1;
  logic [1:0] RD_DATA2;
  joy_word_t  JOY1;
  joy_word_t  JOY2;
  joy_word_t  JOY3;
  joy_word_t  JOY4;
  logic       BUSY;

  modport master (
    input  AUTO_EN, VBLANK_START, WRIO7, LATCH_WR, LATCH_D, RD4016, RD4017,
    input  P1_DO, P2_DO,
    output PORT_LATCH, P1_CLK, P2_CLK, PORT_P6, RD_DATA1, RD_DATA2,
    output JOY1, JOY2, JOY3, JOY4, BUSY
  );

  modport slave (
    output AUTO_EN, VBLANK_START, WRIO7, LATCH_WR, LATCH_D, RD4016, RD4017,
    output P1_DO, P2_DO,
    input  PORT_LATCH, P1_CLK, P2_CLK, PORT_P6, RD_DATA1, RD_DATA2,
    input  JOY1, JOY2, JOY3, JOY4, BUSY
  );

endinterface

// File: rtl/joy_ctr.sv
// CE-gated down-counter: load wins over counting, holds at zero, flags zero.
module joy_ctr #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (ce && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/joy_autoread.sv
// SNES controller-port master: VBlank auto-joypad read plus manual $4016/$4017 access.
module joy_autoread
  import snes_joy_pkg::*;
#(
  parameter int LATCH_CYC   = 256,
  parameter int HALF_CYC    = 128,
  parameter int MAN_CLK_CYC = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CE,
  joy_autoread_if.master bus
);

  localparam int TMR_W = $clog2(((LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC) + 1);
  localparam int MAN_W = $clog2(MAN_CLK_CYC + 1);
  localparam int CNT_W = $clog2(JOY_BITS);

  // Timers are loaded with N-1 so a phase spans exactly N CE ticks.
  localparam logic [TMR_W-1:0] LATCH_LD = TMR_W'(LATCH_CYC - 1);
  localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(HALF_CYC - 1);
  localparam logic [MAN_W-1:0] MAN_LD   = MAN_W'(MAN_CLK_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(JOY_BITS - 1);

  joy_state_t       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             tmr_load, tmr_zero, start, shift_en, cnt_inc;
  logic [TMR_W-1:0] tmr_val;
  logic             busy, man_latch;
  logic             man1_active, man2_active, man1_load, man2_load, man1_zero, man2_zero;
  joy_word_t        joy1, joy2, joy3, joy4;
  logic [1:0]       rd_data1, rd_data2;

  joy_ctr #(.W(TMR_W)) u_phase (
    .CLK(CLK), .RST(RST), .ce(CE), .load(tmr_load), .load_val(tmr_val), .zero(tmr_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    start     = 1'b0;
    shift_en  = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: if (bus.VBLANK_START && bus.AUTO_EN) begin
        state_nxt = LATCH;
        tmr_load  = 1'b1;
        tmr_val   = LATCH_LD;
        start     = 1'b1;
      end
      LATCH: if (CE && tmr_zero) begin
        state_nxt = BIT_LO;
        tmr_load  = 1'b1;
        tmr_val   = HALF_LD;
        shift_en  = 1'b1;
      end
      BIT_LO: if (CE && tmr_zero) begin
        state_nxt = BIT_HI;
        tmr_load  = 1'b1;
        tmr_val   = HALF_LD;
      end
      BIT_HI: if (CE && tmr_zero) begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BIT_LO;
          tmr_load  = 1'b1;
          tmr_val   = HALF_LD;
          shift_en  = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      joy1    <= '0;
      joy2    <= '0;
      joy3    <= '0;
      joy4    <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        bit_cnt <= '0;
        joy1    <= '0;
        joy2    <= '0;
        joy3    <= '0;
        joy4    <= '0;
      end else begin
        if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);
        if (shift_en) begin
          joy1 <= shift_in(joy1, ~bus.P1_DO[0]);
          joy2 <= shift_in(joy2, ~bus.P2_DO[0]);
          joy3 <= shift_in(joy3, ~bus.P1_DO[1]);
          joy4 <= shift_in(joy4, ~bus.P2_DO[1]);
        end
      end
    end
  end

  assign busy = (state != IDLE);

  // Manual strobes always capture; the clock pulse is withheld while the auto-read owns the lines.
  assign man1_load = bus.RD4016 && !busy;
  assign man2_load = bus.RD4017 && !busy;

  joy_ctr #(.W(MAN_W)) u_man1 (
    .CLK(CLK), .RST(RST), .ce(CE), .load(man1_load), .load_val(MAN_LD), .zero(man1_zero)
  );

  joy_ctr #(.W(MAN_W)) u_man2 (
    .CLK(CLK), .RST(RST), .ce(CE), .load(man2_load), .load_val(MAN_LD), .zero(man2_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      man_latch   <= 1'b0;
      rd_data1    <= '0;
      rd_data2    <= '0;
      man1_active <= 1'b0;
      man2_active <= 1'b0;
    end else begin
      if (bus.LATCH_WR) man_latch <= bus.LATCH_D;
      if (bus.RD4016)   rd_data1  <= ~bus.P1_DO;
      if (bus.RD4017)   rd_data2  <= ~bus.P2_DO;

      if (man1_load)               man1_active <= 1'b1;
      else if (CE && man1_zero)    man1_active <= 1'b0;

      if (man2_load)               man2_active <= 1'b1;
      else if (CE && man2_zero)    man2_active <= 1'b0;
    end
  end

  assign bus.PORT_LATCH = (state == LATCH) || man_latch;
  assign bus.P1_CLK     = !((state == BIT_LO) || man1_active);
  assign bus.P2_CLK     = !((state == BIT_LO) || man2_active);
  assign bus.PORT_P6    = bus.WRIO7;
  assign bus.RD_DATA1   = rd_data1;
  assign bus.RD_DATA2   = rd_data2;
  assign bus.JOY1       = joy1;
  assign bus.JOY2       = joy2;
  assign bus.JOY3       = joy3;
  assign bus.JOY4       = joy4;
  assign bus.BUSY       = busy;

endmodule
